aes_seq_ctrl: RTL and testbench

Sequencer that sits between a host word-stream interface and the `key_xpa` / `cipher_eng` pair. It buffers one key of 4, 6 or 8 words and one 4-word data block from the host. It launches both engines with a single shared start pulse and replays key and data words on consecutive cycles. It then collects the 4 cipher output words and returns them to the host over a valid/ready handshake, with a watchdog on the engine.

---
 rtl/aes_seq_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_aes_seq_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_seq_ctrl.sv
// Purpose: buffers a 4/6/8-word key and a 4-word block, launches key_xpa/cipher_eng, returns 4 result words.
// Latency: first start 1 cycle after the last load word is accepted; result valid 1 cycle after the 4th capture.
// Backpressure: key/data streams stall on their own ready; each result word holds until res_ready_in.
module aes_seq_ctrl #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [1:0]  cmd_conf_in,
  input  logic        cmd_keep_key_in,
  input  logic [31:0] key_in,
  input  logic        key_valid_in,
  output logic        key_ready_out,
  input  logic [31:0] data_in,
  input  logic        data_valid_in,
  output logic        data_ready_out,
  output logic        eng_start_out,
  output logic [1:0]  eng_conf_out,
  output logic [31:0] eng_key_out,
  output logic [31:0] eng_data_out,
  input  logic        eng_dvalid_in,
  input  logic [31:0] eng_data_in,
  output logic [31:0] res_data_out,
  output logic        res_valid_out,
  input  logic        res_ready_in,
  output logic        busy_out,
  output logic        err_out
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_LAUNCH  = 3'd2,
    S_WAIT    = 3'd3,
    S_COLLECT = 3'd4,
    S_DRAIN   = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     conf_q, conf_d;
  logic [3:0]     nk_q, nk_d;
  logic           keep_q, keep_d;
  logic           key_ok_q, key_ok_d;
  logic [3:0]     kcnt_q, kcnt_d;
  logic [2:0]     dcnt_q, dcnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [2:0]     rcnt_q, rcnt_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           err_q, err_d;
  logic [31:0]    key_q [8];
  logic [31:0]    key_d [8];
  logic [31:0]    dat_q [4];
  logic [31:0]    dat_d [4];
  logic [31:0]    res_q [4];
  logic [31:0]    res_d [4];

  logic key_hs, dat_hs, res_hs;

  // Output decode: everything the host and engines see comes straight from registered state.
  assign cmd_ready_out  = (state_q == S_IDLE);
  assign busy_out       = (state_q != S_IDLE);
  assign key_ready_out  = (state_q == S_LOAD) && !keep_q && (kcnt_q != nk_q);
  assign data_ready_out = (state_q == S_LOAD) && (dcnt_q != 3'd4);
  assign eng_start_out  = (state_q == S_LAUNCH) && (idx_q == 3'd0);
  assign eng_key_out    = (state_q == S_LAUNCH) ? key_q[idx_q] : 32'h0;
  // Only 4 data words exist; launch slots 4..7 of a long key carry zero data.
  assign eng_data_out   = ((state_q == S_LAUNCH) && !idx_q[2]) ? dat_q[idx_q[1:0]] : 32'h0;
  assign res_valid_out  = (state_q == S_DRAIN);
  assign res_data_out   = res_valid_out ? res_q[ptr_q] : 32'h0;
  assign eng_conf_out   = conf_q;
  assign err_out        = err_q;

  assign key_hs = key_valid_in & key_ready_out;
  assign dat_hs = data_valid_in & data_ready_out;
  assign res_hs = res_valid_out & res_ready_in;

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Datapath registers: config, counters, watchdog, key/data/result buffers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      conf_q   <= 2'd0;
      nk_q     <= 4'd0;
      keep_q   <= 1'b0;
      key_ok_q <= 1'b0;
      kcnt_q   <= 4'd0;
      dcnt_q   <= 3'd0;
      idx_q    <= 3'd0;
      rcnt_q   <= 3'd0;
      ptr_q    <= 2'd0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < 8; i++) key_q[i] <= 32'h0;
      for (int i = 0; i < 4; i++) dat_q[i] <= 32'h0;
      for (int i = 0; i < 4; i++) res_q[i] <= 32'h0;
    end else begin
      conf_q   <= conf_d;
      nk_q     <= nk_d;
      keep_q   <= keep_d;
      key_ok_q <= key_ok_d;
      kcnt_q   <= kcnt_d;
      dcnt_q   <= dcnt_d;
      idx_q    <= idx_d;
      rcnt_q   <= rcnt_d;
      ptr_q    <= ptr_d;
      wdog_q   <= wdog_d;
      err_q    <= err_d;
      for (int i = 0; i < 8; i++) key_q[i] <= key_d[i];
      for (int i = 0; i < 4; i++) dat_q[i] <= dat_d[i];
      for (int i = 0; i < 4; i++) res_q[i] <= res_d[i];
    end
  end

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d  = state_q;
    conf_d   = conf_q;
    nk_d     = nk_q;
    keep_d   = keep_q;
    key_ok_d = key_ok_q;
    kcnt_d   = kcnt_q;
    dcnt_d   = dcnt_q;
    idx_d    = idx_q;
    rcnt_d   = rcnt_q;
    ptr_d    = ptr_q;
    wdog_d   = wdog_q;
    err_d    = 1'b0;
    key_d    = key_q;
    dat_d    = dat_q;
    res_d    = res_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_in) begin
          if (cmd_conf_in == 2'd3) begin
            err_d = 1'b1;
          end else if (cmd_keep_key_in && !key_ok_q) begin
            err_d = 1'b1;
          end else begin
            conf_d = cmd_conf_in;
            case (cmd_conf_in)
              2'd0:    nk_d = 4'd4;
              2'd1:    nk_d = 4'd6;
              default: nk_d = 4'd8;
            endcase
            keep_d  = cmd_keep_key_in;
            kcnt_d  = 4'd0;
            dcnt_d  = 3'd0;
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (key_hs) begin
          key_d[kcnt_q[2:0]] = key_in;
          kcnt_d = kcnt_q + 4'd1;
        end
        if (dat_hs) begin
          dat_d[dcnt_q[1:0]] = data_in;
          dcnt_d = dcnt_q + 3'd1;
        end
        // Completion includes this cycle's handshakes so launch follows the last word directly.
        if ((keep_q || (kcnt_d == nk_q)) && (dcnt_d == 3'd4)) begin
          key_ok_d = 1'b1;
          idx_d    = 3'd0;
          state_d  = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        if ({1'b0, idx_q} == (nk_q - 4'd1)) begin
          wdog_d  = '0;
          rcnt_d  = 3'd0;
          state_d = S_WAIT;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end

      // WAIT and COLLECT differ only in how many words are already held;
      // a captured word wins over a simultaneous watchdog expiry.
      S_WAIT, S_COLLECT: begin
        if (eng_dvalid_in) begin
          res_d[rcnt_q[1:0]] = eng_data_in;
          rcnt_d = rcnt_q + 3'd1;
          wdog_d = '0;
          if (rcnt_q == 3'd3) begin
            ptr_d   = 2'd0;
            state_d = S_DRAIN;
          end else begin
            state_d = S_COLLECT;
          end
        end else if (wdog_q == WD_MAX) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end

      S_DRAIN: begin
        if (res_hs) begin
          ptr_d = ptr_q + 2'd1;
          if (ptr_q == 2'd3) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Scoreboard bench for aes_seq_ctrl: stimulus pushes expected launch streams, results and error cycles.
// Independent monitors pop and compare whenever the DUT presents a start pulse, a result or an error.
// A stub engine returns chosen cipher words with random gaps, junk during launch and a stray 5th word.
module tb_aes_seq_ctrl;
  localparam int unsigned TIMEOUT = 1023;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        cmd_valid_in, cmd_ready_out, cmd_keep_key_in;
  logic [1:0]  cmd_conf_in;
  logic [31:0] key_in, data_in;
  logic        key_valid_in, key_ready_out, data_valid_in, data_ready_out;
  logic        eng_start_out;
  logic [1:0]  eng_conf_out;
  logic [31:0] eng_key_out, eng_data_out;
  logic        eng_dvalid_in;
  logic [31:0] eng_data_in;
  logic [31:0] res_data_out;
  logic        res_valid_out, res_ready_in, busy_out, err_out;

  aes_seq_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_conf_in(cmd_conf_in), .cmd_keep_key_in(cmd_keep_key_in),
    .key_in(key_in), .key_valid_in(key_valid_in), .key_ready_out(key_ready_out),
    .data_in(data_in), .data_valid_in(data_valid_in), .data_ready_out(data_ready_out),
    .eng_start_out(eng_start_out), .eng_conf_out(eng_conf_out),
    .eng_key_out(eng_key_out), .eng_data_out(eng_data_out),
    .eng_dvalid_in(eng_dvalid_in), .eng_data_in(eng_data_in),
    .res_data_out(res_data_out), .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .busy_out(busy_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0]        nk;
    logic [1:0]        conf;
    logic              tmo;
    logic [7:0][31:0]  key;
    logic [3:0][31:0]  dat;
  } launch_t;

  int checks = 0;
  int failures = 0;

  launch_t     exp_launch_q[$];
  logic [31:0] exp_res_q[$];
  int          exp_err_q[$];

  // Reference model of the stored key: what the host loaded last, lost on reset.
  logic [7:0][31:0] m_key;
  bit               m_key_ok;

  int               stub_nk, stub_mode, stub_emitted;
  logic [3:0][31:0] stub_vec;
  int               rr_mode;
  int               last_load_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_cmd_ready", {31'd0, cmd_ready_out}, 32'd1);
    chk("rst_flags", {24'd0, eng_start_out, busy_out, err_out, res_valid_out,
                      key_ready_out, data_ready_out, eng_conf_out}, 32'd0);
    chk("rst_eng_key", eng_key_out, 32'd0);
    chk("rst_eng_data", eng_data_out, 32'd0);
    chk("rst_res_data", res_data_out, 32'd0);
  endtask

  // Host-side record of the last accepted load word, for launch latency.
  always @(negedge clk_in)
    if (rst_in && ((key_valid_in && key_ready_out) || (data_valid_in && data_ready_out)))
      last_load_cyc = cyc;

  // Launch monitor: every start pulse must match the next expected launch stream.
  initial begin
    launch_t l;
    int s;
    logic [31:0] ed;
    forever begin
      @(negedge clk_in);
      if (rst_in && eng_start_out) begin
        if (exp_launch_q.size() == 0) begin
          chk("unexpected_start", 32'd1, 32'd0);
        end else begin
          l = exp_launch_q.pop_front();
          s = cyc;
          chk("launch_latency", s, last_load_cyc + 1);
          chk("eng_conf", {30'd0, eng_conf_out}, {30'd0, l.conf});
          for (int i = 0; i < int'(l.nk); i++) begin
            if (i > 0) @(negedge clk_in);
            ed = (i < 4) ? l.dat[i % 4] : 32'h0;
            chk("launch_start", {31'd0, eng_start_out}, (i == 0) ? 32'd1 : 32'd0);
            chk("launch_key", eng_key_out, l.key[i]);
            chk("launch_data", eng_data_out, ed);
          end
          @(negedge clk_in);
          chk("post_launch_zero", {eng_key_out | eng_data_out}, 32'd0);
          if (l.tmo) exp_err_q.push_back(s + int'(l.nk) + int'(TIMEOUT) + 1);
        end
      end
    end
  end

  // Result monitor: the presented word always equals the head of the scoreboard; pop on handshake.
  always @(negedge clk_in) begin
    if (rst_in && res_valid_out) begin
      if (exp_res_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        chk("res_data", res_data_out, exp_res_q[0]);
        if (res_ready_in) void'(exp_res_q.pop_front());
      end
    end
  end

  // Error monitor: each pulse must land on the cycle the model predicted.
  always @(negedge clk_in) begin
    if (rst_in && err_out) begin
      if (exp_err_q.size() == 0) chk("unexpected_err", 32'd1, 32'd0);
      else chk("err_cycle", cyc, exp_err_q.pop_front());
    end
  end

  // Idle monitor: nothing but cmd_ready may be active while not busy.
  always @(negedge clk_in) begin
    if (rst_in && !busy_out) begin
      chk("idle_outputs", {26'd0, eng_start_out, res_valid_out, key_ready_out, data_ready_out,
                           |eng_key_out, |eng_data_out}, 32'd0);
      chk("idle_cmd_ready", {31'd0, cmd_ready_out}, 32'd1);
    end
  end

  // Stub engine: junk dvalid during launch, then the chosen words with random gaps.
  int s_nk, s_mode, s_nw;
  initial begin
    eng_dvalid_in = 1'b0;
    eng_data_in   = 32'h0;
    forever begin
      @(negedge clk_in);
      if (rst_in && eng_start_out) begin
        s_nk   = stub_nk;
        s_mode = stub_mode;
        @(posedge clk_in); #1;
        for (int j = 1; j < s_nk; j++) begin
          eng_dvalid_in = 1'b1;
          eng_data_in   = $urandom;
          @(posedge clk_in); #1;
        end
        eng_dvalid_in = 1'b0;
        s_nw = (s_mode == 0) ? 4 + int'($urandom_range(0, 1)) : ((s_mode == 2) ? 2 : 0);
        for (int w = 0; w < s_nw; w++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk_in); #1; end
          eng_dvalid_in = 1'b1;
          eng_data_in   = (w < 4) ? stub_vec[w % 4] : $urandom;
          @(posedge clk_in); #1;
          eng_dvalid_in = 1'b0;
        end
        stub_emitted = s_nw;
      end
    end
  end

  // Host result-ready pattern: always, toggling, or random.
  initial begin
    res_ready_in = 1'b0;
    forever begin
      @(posedge clk_in); #1;
      case (rr_mode)
        0:       res_ready_in = 1'b1;
        1:       res_ready_in = ~res_ready_in;
        default: res_ready_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // mode 0: normal, 1: engine silent (watchdog), 2: reset after 2 captured words.
  task automatic run_op(input logic [1:0] conf, input bit keep, input logic [7:0][31:0] k,
                        input logic [3:0][31:0] d, input logic [3:0][31:0] r, input int mode);
    int nk, c0, n;
    launch_t l;
    @(posedge clk_in); #1;
    cmd_valid_in = 1'b1; cmd_conf_in = conf; cmd_keep_key_in = keep;
    c0 = cyc;
    if (conf == 2'd3 || (keep && !m_key_ok)) begin
      exp_err_q.push_back(c0 + 1);
      @(posedge clk_in); #1;
      cmd_valid_in = 1'b0;
      repeat (3) begin @(negedge clk_in); chk("err_busy", {31'd0, busy_out}, 32'd0); end
      return;
    end
    nk = 4 + 2 * int'(conf);
    for (int i = 0; i < nk; i++) if (!keep) m_key[i] = k[i];
    m_key_ok = 1'b1;
    l.nk = nk[3:0]; l.conf = conf; l.tmo = (mode == 1); l.key = m_key; l.dat = d;
    exp_launch_q.push_back(l);
    if (mode == 0) for (int i = 0; i < 4; i++) exp_res_q.push_back(r[i]);
    stub_nk = nk; stub_mode = mode; stub_vec = r; stub_emitted = 0;
    @(posedge clk_in); #1;
    cmd_valid_in = 1'b0;
    fork
      begin
        int kn; bit khs;
        if (!keep) for (int i = 0; i < nk; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk_in); #1; end
          key_valid_in = 1'b1; key_in = k[i]; kn = 0;
          do begin
            @(negedge clk_in); khs = key_ready_out;
            @(posedge clk_in); #1; kn++;
          end while (!khs && kn < 50);
          key_valid_in = 1'b0;
          if (!khs) chk("key_hs_timeout", 32'd0, 32'd1);
        end
      end
      begin
        int dn; bit dhs;
        for (int i = 0; i < 4; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk_in); #1; end
          data_valid_in = 1'b1; data_in = d[i]; dn = 0;
          do begin
            @(negedge clk_in); dhs = data_ready_out;
            if (keep) chk("keep_key_ready", {31'd0, key_ready_out}, 32'd0);
            @(posedge clk_in); #1; dn++;
          end while (!dhs && dn < 50);
          data_valid_in = 1'b0;
          if (!dhs) chk("data_hs_timeout", 32'd0, 32'd1);
        end
      end
    join
    if (mode == 2) begin
      n = 0;
      while (stub_emitted < 2 && n < 100) begin @(posedge clk_in); #1; n++; end
      chk("collect_reached", stub_emitted, 32'd2);
      #2;
      rst_in = 1'b0;
      exp_res_q.delete();
      m_key_ok = 1'b0; m_key = '0;
      #1;
      check_reset_outputs();
      repeat (2) @(posedge clk_in);
      #1; rst_in = 1'b1;
    end else begin
      n = 0;
      while (busy_out && n < int'(TIMEOUT) + 200) begin @(posedge clk_in); #1; n++; end
      chk("op_done", {31'd0, busy_out}, 32'd0);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit reached");
  end

  logic [7:0][31:0] fk, rk;
  logic [3:0][31:0] fd, fr, rd, rr;
  logic [1:0] rc;
  bit rkeep;

  initial begin
    rst_in = 1'b0;
    cmd_valid_in = 1'b0; cmd_conf_in = 2'd0; cmd_keep_key_in = 1'b0;
    key_in = 32'h0; key_valid_in = 1'b0; data_in = 32'h0; data_valid_in = 1'b0;
    rr_mode = 0; stub_nk = 4; stub_mode = 0; stub_emitted = 0; stub_vec = '0;
    m_key = '0; m_key_ok = 1'b0;
    fk = '0; rk = '0; fd = '0; fr = '0; rd = '0; rr = '0;
    fk[0] = 32'h00010203; fk[1] = 32'h04050607; fk[2] = 32'h08090a0b; fk[3] = 32'h0c0d0e0f;
    fd[0] = 32'h00112233; fd[1] = 32'h44556677; fd[2] = 32'h8899aabb; fd[3] = 32'hccddeeff;
    fr[0] = 32'h69c4e0d8; fr[1] = 32'h6a7b0430; fr[2] = 32'hd8cdb780; fr[3] = 32'h70b4c55a;

    repeat (3) @(negedge clk_in);
    check_reset_outputs();
    @(posedge clk_in); #1; rst_in = 1'b1;

    // Keep-key with nothing stored, then illegal conf.
    run_op(2'd0, 1'b1, fk, fd, fr, 0);
    run_op(2'd3, 1'b0, fk, fd, fr, 0);

    // FIPS-197 AES-128 vector, then reuse of that key with fresh data.
    run_op(2'd0, 1'b0, fk, fd, fr, 0);
    for (int i = 0; i < 4; i++) begin rd[i] = $urandom; rr[i] = $urandom; end
    run_op(2'd0, 1'b1, fk, rd, rr, 0);

    // AES-256 with toggling result ready.
    rr_mode = 1;
    for (int i = 0; i < 8; i++) rk[i] = $urandom;
    for (int i = 0; i < 4; i++) begin rd[i] = $urandom; rr[i] = $urandom; end
    run_op(2'd2, 1'b0, rk, rd, rr, 0);

    // Watchdog: engine never answers.
    rr_mode = 0;
    run_op(2'd1, 1'b0, rk, rd, rr, 1);

    // Reset mid-COLLECT: key lost, keep-key now errors, normal command still works.
    run_op(2'd0, 1'b0, fk, fd, fr, 2);
    run_op(2'd0, 1'b1, fk, fd, fr, 0);
    run_op(2'd0, 1'b0, fk, fd, fr, 0);

    // Randomised commands.
    for (int t = 0; t < 14; t++) begin
      rc    = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rkeep = ($urandom_range(0, 2) == 0);
      rr_mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 8; i++) rk[i] = $urandom;
      for (int i = 0; i < 4; i++) begin rd[i] = $urandom; rr[i] = $urandom; end
      run_op(rc, rkeep, rk, rd, rr, 0);
    end

    repeat (10) @(posedge clk_in);
    chk("launch_q_empty", exp_launch_q.size(), 32'd0);
    chk("res_q_empty", exp_res_q.size(), 32'd0);
    chk("err_q_empty", exp_err_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
